// File: rtl/psg_sched_pkg.sv
// Shared types and constants for the PSG register-bus scheduler.
package psg_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RADDR,
    ST_RCAP
  } sched_state_e;

  localparam logic [3:0]  PSG_ENV_SHAPE_ADDR = 4'hD;
  localparam int unsigned STROBE_CNT_W       = 4;

endpackage

// File: rtl/psg_rr_arb2.sv
// Two-port arbiter (host / player) with a last-grant pointer.
// grant[0] = host, grant[1] = player; the pointer only moves on an accept.
module psg_rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_h,
  input  logic       req_p,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_host;

  always_comb begin
    grant = '0;
    // On a tie the host wins if it is prioritised or did not win last time.
    if (req_h && (!req_p || (FIXED_PRIO != 0) || !last_host)) begin
      grant[0] = 1'b1;
    end else if (req_p) begin
      grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_host <= 1'b0;
    end else if (accept) begin
      last_host <= grant[0];
    end
  end

endmodule

// File: rtl/psg_bus_sched.sv
// Shares the PSG register port between a host (read/write) and a player (write-only).
// Optional read path: define PSG_SCHED_READ_EN to build the RADDR/RCAP sequence.
module psg_bus_sched
  import psg_sched_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned FIXED_PRIO    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_valid,
  output logic       h_ready,
  input  logic       h_we,
  input  logic [3:0] h_addr,
  input  logic [7:0] h_wdata,
  output logic       h_rvalid,
  output logic [7:0] h_rdata,
  input  logic       p_valid,
  output logic       p_ready,
  input  logic [3:0] p_addr,
  input  logic [7:0] p_wdata,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  input  logic [7:0] psg_dout,
  output logic       busy
);

  localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

  sched_state_e            state, state_nxt;
  logic [STROBE_CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]              grant;
  logic                    accept, acc_wr, acc_rd;
  logic [3:0]              acc_addr;
  logic [7:0]              acc_data;

  psg_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_h  (h_valid),
    .req_p  (p_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign h_ready  = (state == ST_IDLE) && grant[0];
  assign p_ready  = (state == ST_IDLE) && grant[1];
  assign accept   = h_ready || p_ready;
  assign acc_wr   = p_ready || (h_ready && h_we);
  assign acc_rd   = h_ready && !h_we;
  assign acc_addr = grant[0] ? h_addr  : p_addr;
  assign acc_data = grant[0] ? h_wdata : p_wdata;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (acc_wr) begin
          state_nxt = ST_SETUP;
`ifdef PSG_SCHED_READ_EN
        end else if (acc_rd) begin
          state_nxt = ST_RADDR;
`endif
        end
      end
      ST_SETUP: begin
        state_nxt = ST_STROBE;
        cnt_nxt   = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (cnt == '0) state_nxt = ST_HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_HOLD:  state_nxt = ST_IDLE;
`ifdef PSG_SCHED_READ_EN
      ST_RADDR: state_nxt = ST_RCAP;
      ST_RCAP:  state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      psg_addr <= '0;
      psg_din  <= '0;
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      psg_cs_n <= !((state_nxt == ST_SETUP) || (state_nxt == ST_STROBE));
      psg_wr_n <= (state_nxt != ST_STROBE);
      if (acc_wr) begin
        psg_addr <= acc_addr;
        psg_din  <= acc_data;
      end
`ifdef PSG_SCHED_READ_EN
      else if (acc_rd) begin
        psg_addr <= h_addr;
      end
      h_rvalid <= (state == ST_RCAP);
      if (state == ST_RCAP) h_rdata <= psg_dout;
`else
      h_rvalid <= acc_rd;
      h_rdata  <= '0;
`endif
    end
  end

`ifndef PSG_SCHED_READ_EN
  logic unused_dout;
  assign unused_dout = ^psg_dout;
`endif

endmodule

// File: tb/tb_psg_bus_sched.sv
// Randomised bench for psg_bus_sched against a timeline model of each access.
// Build with or without PSG_SCHED_READ_EN; a second instance covers FIXED_PRIO=1.
module tb_psg_bus_sched;

  localparam int S  = 2;
  localparam int FP = 0;
  localparam int S2 = 1;
`ifdef PSG_SCHED_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, rst2_n = 1'b0;
  logic       h_valid = 1'b0, h_we = 1'b0, p_valid = 1'b0;
  logic [3:0] h_addr = '0, p_addr = '0;
  logic [7:0] h_wdata = '0, p_wdata = '0;
  logic       h_ready, p_ready, h_rvalid, psg_cs_n, psg_wr_n, busy;
  logic [7:0] h_rdata, psg_din;
  logic [3:0] psg_addr;
  logic [7:0] psg_dout = '0;

  logic       h2_valid = 1'b0, p2_valid = 1'b0, h2_we = 1'b1;
  logic [3:0] h2_addr = 4'h3, p2_addr = 4'h4;
  logic [7:0] h2_wdata = 8'h55, p2_wdata = 8'h66, dout2 = '0;
  logic       h2_ready, p2_ready, h2_rvalid, cs2_n, wr2_n, busy2;
  logic [7:0] h2_rdata, din2;
  logic [3:0] addr2;

  psg_bus_sched #(.STROBE_CYCLES(S), .FIXED_PRIO(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_wdata(p_wdata),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n),
    .psg_dout(psg_dout), .busy(busy)
  );

  psg_bus_sched #(.STROBE_CYCLES(S2), .FIXED_PRIO(1)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .h_valid(h2_valid), .h_ready(h2_ready), .h_we(h2_we), .h_addr(h2_addr), .h_wdata(h2_wdata),
    .h_rvalid(h2_rvalid), .h_rdata(h2_rdata),
    .p_valid(p2_valid), .p_ready(p2_ready), .p_addr(p2_addr), .p_wdata(p2_wdata),
    .psg_addr(addr2), .psg_din(din2), .psg_cs_n(cs2_n), .psg_wr_n(wr2_n),
    .psg_dout(dout2), .busy(busy2)
  );

  // PSG register file: written while selected and strobed, read with one cycle latency.
  logic [7:0] psg_regs [16] = '{default: 8'h00};
  int         env_cnt = 0;
  always @(posedge clk) begin
    if (!psg_cs_n && !psg_wr_n) psg_regs[psg_addr] <= psg_din;
    psg_dout <= psg_regs[psg_addr];
  end
  always @(posedge psg_wr_n) if (rst_n === 1'b1 && psg_addr == 4'hD) env_cnt++;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, acc_kind = 0, rv_cyc = -100;
  logic [7:0] rv_data = '0, exp_din = '0;
  logic [3:0] exp_addr = '0;
  logic [7:0] mregs [16] = '{default: 8'h00};
  bit last_host = 1'b0, h_acc = 1'b0, p_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: compare at negedge against the timeline of the last accepted access,
  // then advance the model and return just after the next rising edge.
  task automatic run_cycle();
    int k;
    bit ebusy, ecs, ewr, hg, pg;
    @(negedge clk);
    cyc++;
    k = cyc - acc_cyc;
    ebusy = 1'b0; ecs = 1'b1; ewr = 1'b1;
    if (acc_kind == 1) begin
      ebusy = (k >= 1 && k <= S + 2);
      ecs   = !(k >= 1 && k <= S + 1);
      ewr   = !(k >= 2 && k <= S + 1);
    end else if (acc_kind == 2) begin
      ebusy = (k >= 1 && k <= 2);
    end
    hg = !ebusy && h_valid && (!p_valid || FP != 0 || !last_host);
    pg = !ebusy && p_valid && !hg;
    check("busy",     32'(busy),     32'(ebusy));
    check("psg_cs_n", 32'(psg_cs_n), 32'(ecs));
    check("psg_wr_n", 32'(psg_wr_n), 32'(ewr));
    check("h_ready",  32'(h_ready),  32'(hg));
    check("p_ready",  32'(p_ready),  32'(pg));
    check("h_rvalid", 32'(h_rvalid), 32'(cyc == rv_cyc));
    if (cyc == rv_cyc) check("h_rdata", 32'(h_rdata), 32'(rv_data));
    check("psg_addr", 32'(psg_addr), 32'(exp_addr));
    check("psg_din",  32'(psg_din),  32'(exp_din));
    h_acc = hg;
    p_acc = pg;
    if (hg) begin
      last_host = 1'b1;
      if (h_we) begin
        acc_kind = 1; acc_cyc = cyc;
        exp_addr = h_addr; exp_din = h_wdata; mregs[h_addr] = h_wdata;
      end else if (READ_EN) begin
        acc_kind = 2; acc_cyc = cyc; exp_addr = h_addr;
        rv_cyc = cyc + 3; rv_data = mregs[h_addr];
      end else begin
        rv_cyc = cyc + 1; rv_data = 8'h00;
      end
    end
    if (pg) begin
      last_host = 1'b0;
      acc_kind = 1; acc_cyc = cyc;
      exp_addr = p_addr; exp_din = p_wdata; mregs[p_addr] = p_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic we, input logic [3:0] a, input logic [7:0] d);
    h_valid = 1'b1; h_we = we; h_addr = a; h_wdata = d; h_acc = 1'b0;
    for (int i = 0; i < 64 && !h_acc; i++) run_cycle();
    if (!h_acc) check("host_req_timeout", 32'(h_acc), 32'd1);
    h_valid = 1'b0;
  endtask

  task automatic player_req(input logic [3:0] a, input logic [7:0] d);
    p_valid = 1'b1; p_addr = a; p_wdata = d; p_acc = 1'b0;
    for (int i = 0; i < 64 && !p_acc; i++) run_cycle();
    if (!p_acc) check("player_req_timeout", 32'(p_acc), 32'd1);
    p_valid = 1'b0;
  endtask

  initial begin
    int e0;
    logic [7:0] old5;

    // Fixed-priority instance: both ports hammer writes, only the host is ever served.
    h2_valid = 1'b1; p2_valid = 1'b1;
    @(posedge clk); #1; rst2_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      int ph;
      @(negedge clk);
      ph = c % (S2 + 3);
      check("fp_h_ready", 32'(h2_ready), 32'(ph == 0));
      check("fp_p_ready", 32'(p2_ready), 32'd0);
      check("fp_cs_n",    32'(cs2_n),    32'(!(ph >= 1 && ph <= S2 + 1)));
      check("fp_wr_n",    32'(wr2_n),    32'(!(ph >= 2 && ph <= S2 + 1)));
      @(posedge clk); #1;
    end
    h2_valid = 1'b0; p2_valid = 1'b0;

    // Main instance out of reset.
    check("rst_cs_n",  32'(psg_cs_n), 32'd1);
    check("rst_wr_n",  32'(psg_wr_n), 32'd1);
    check("rst_rdata", 32'(h_rdata),  32'd0);
    rst_n = 1'b1;
    repeat (2) run_cycle();

    host_req(1'b1, 4'h8, 8'h1F);
    repeat (S + 4) run_cycle();

    host_req(1'b1, 4'h0, 8'hA5);
    host_req(1'b0, 4'h0, 8'h00);
    repeat (5) run_cycle();

    // Both ports requesting continuously.
    h_valid = 1'b1; h_we = 1'b1; h_addr = 4'h1; h_wdata = 8'h10;
    p_valid = 1'b1; p_addr = 4'h2; p_wdata = 8'h20;
    for (int n = 0; n < 6 * (S + 3); n++) begin
      run_cycle();
      if (h_acc) h_wdata = h_wdata + 8'd1;
      if (p_acc) p_wdata = p_wdata + 8'd1;
    end
    h_valid = 1'b0; p_valid = 1'b0;
    repeat (S + 4) run_cycle();

    // Back-to-back envelope-shape writes.
    e0 = env_cnt;
    player_req(4'hD, 8'h0E);
    player_req(4'hD, 8'h0A);
    repeat (S + 4) run_cycle();
    check("env_restarts", 32'(env_cnt - e0), 32'd2);
    check("env_shape",    32'(psg_regs[13]), 32'h0A);

    for (int n = 0; n < 400; n++) begin
      if (!h_valid && $urandom_range(0, 2) == 0) begin
        h_valid = 1'b1; h_we = 1'($urandom_range(0, 1));
        h_addr = 4'($urandom); h_wdata = 8'($urandom);
      end
      if (!p_valid && $urandom_range(0, 2) == 0) begin
        p_valid = 1'b1; p_addr = 4'($urandom); p_wdata = 8'($urandom);
      end
      run_cycle();
      if (h_acc) h_valid = 1'b0;
      if (p_acc) p_valid = 1'b0;
    end
    h_valid = 1'b0; p_valid = 1'b0;
    repeat (S + 4) run_cycle();

    // Reset pulsed in the middle of the strobe; the aborted write never lands.
    old5 = mregs[5];
    host_req(1'b1, 4'h5, 8'h3C);
    run_cycle();
    #2;
    check("pre_rst_wr_n", 32'(psg_wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_cs_n", 32'(psg_cs_n), 32'd1);
    check("rst_async_wr_n", 32'(psg_wr_n), 32'd1);
    check("rst_async_busy", 32'(busy),     32'd0);
    @(negedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    mregs[5] = old5; acc_kind = 0; last_host = 1'b0; rv_cyc = -100;
    exp_addr = '0; exp_din = '0;
    run_cycle();
    host_req(1'b0, 4'h5, 8'h00);
    repeat (4) run_cycle();
    host_req(1'b1, 4'h6, 8'h77);
    player_req(4'h7, 8'h99);
    repeat (S + 4) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psg_bus_sched.md
# psg_bus_sched

Register-bus scheduler for the YM2149-compatible PSG core. It shares the PSG's single write/read register port between two requesters: a host CPU port with read and write, and a write-only music-player port. It arbitrates between them and sequences each access as a clean cs_n/wr_n transaction. Each write therefore produces exactly one rising write edge in the PSG, which keeps the envelope restart on register 0xD reliable.

## Interface
Parameters:
- STROBE_CYCLES, 2: number of clk cycles wr_n is held low per write; legal range 1..15.
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 gives the host port absolute priority.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- h_valid  in  1  host request valid.
- h_ready  out  1  host request accepted this cycle.
- h_we  in  1  1 = write, 0 = read.
- h_addr  in  4  host register address.
- h_wdata  in  8  host write data.
- h_rvalid  out  1  one-cycle pulse; h_rdata is valid.
- h_rdata  out  8  read data.
- p_valid  in  1  player write request valid.
- p_ready  out  1  player request accepted this cycle.
- p_addr  in  4  player register address.
- p_wdata  in  8  player write data.
- psg_addr  out  4  to PSG addr.
- psg_din  out  8  to PSG din.
- psg_cs_n  out  1  to PSG cs_n.
- psg_wr_n  out  1  to PSG wr_n.
- psg_dout  in  8  from PSG dout (registered in the PSG, 1-cycle latency).
- busy  out  1  state is not IDLE.

## Operation
- Handshake:
  - A request completes on valid & ready.
  - The requester holds valid, addr, data and we stable until ready.
  - ready is asserted only in IDLE, only for the granted port, and only for one cycle.
- Arbitration (evaluated in IDLE):
  - Only one port valid: that port is granted.
  - Both ports valid, FIXED_PRIO=0: the port not granted last time wins. The last-grant pointer resets to "player", so the host wins the first tie.
  - Both ports valid, FIXED_PRIO=1: the host always wins.
- FSM states: IDLE, SETUP, STROBE, HOLD, RADDR, RCAP.
  - IDLE → SETUP on an accepted write. Address and data are latched into psg_addr/psg_din in the same cycle.
  - SETUP (1 cycle): cs_n=0, wr_n=1.
  - STROBE (STROBE_CYCLES cycles, 4-bit counter): cs_n=0, wr_n=0.
  - HOLD (1 cycle): cs_n=1, wr_n=1, which guarantees a write-edge gap before the next access. HOLD → IDLE.
  - IDLE → RADDR on an accepted host read. psg_addr is latched, cs_n and wr_n stay 1.
  - RADDR (1 cycle) → RCAP.
  - RCAP: psg_dout is captured into h_rdata, h_rvalid=1 for this cycle, then → IDLE.
- psg_addr and psg_din keep their last values after an access completes.
- Write throughput: one write per STROBE_CYCLES+3 cycles, counting the IDLE accept cycle.
- Registered outputs: psg_cs_n, psg_wr_n, psg_addr, psg_din, h_rdata, h_rvalid.

## Timing
- Reset values:
  - psg_cs_n=1, psg_wr_n=1.
  - psg_addr=0, psg_din=0.
  - h_ready=0, p_ready=0, h_rvalid=0, h_rdata=0, busy=0.
  - State IDLE; last-grant pointer = player.
- Asserting rst_n mid-transaction:
  - cs_n and wr_n go high immediately (asynchronously).
  - An in-flight request is dropped and never acknowledged again.
  - The requester must re-issue it.
- Write accepted at cycle T:
  - SETUP at T+1.
  - wr_n low during T+2 .. T+1+STROBE_CYCLES.
  - HOLD at T+2+STROBE_CYCLES.
  - IDLE at T+3+STROBE_CYCLES; a new request can be accepted in that cycle.
- Read accepted at T: RADDR at T+1, h_rvalid and h_rdata valid at T+3.
- Back-to-back writes to the same address, including 0xD, each produce a separate low pulse on wr_n.

## Configuration
- PSG_SCHED_READ_EN defined:
  - The RADDR and RCAP path is built as described above.
- PSG_SCHED_READ_EN undefined:
  - The read path is removed.
  - A host request with h_we=0 is still accepted, with no PSG bus activity.
  - h_rvalid pulses at T+1 with h_rdata=8'h00.

## Structure
- Package psg_sched_pkg contains:
  - the state enum;
  - PSG_ENV_SHAPE_ADDR = 4'hD;
  - the STROBE counter width constant (4).
- Sub-module psg_rr_arb2: 2-input arbiter with the last-grant pointer and the FIXED_PRIO parameter. It outputs a one-hot grant and updates the pointer on accept.

## Test plan
- Reset, then host write addr=0x8 data=0x1F, STROBE_CYCLES=2:
  - h_ready at T.
  - cs_n low during T+1..T+3, wr_n low during T+2..T+3.
  - psg_addr=0x8, psg_din=0x1F.
  - busy clears at T+5.
- Host and player both valid with writes continuously, FIXED_PRIO=0: grants alternate host, player, host, player; each write is separated by a HOLD cycle with cs_n=1.
- Same stimulus with FIXED_PRIO=1: the host is granted every time; p_ready stays 0 while h_valid is held.
- Two consecutive player writes to 0xD with data 0x0E, then 0x0A: two distinct wr_n low pulses with cs_n=1 between them; the PSG model sees two envelope restarts.
- Host read of addr 0x0 after writing 0xA5, with PSG_SCHED_READ_EN defined: h_rvalid at T+3 with h_rdata=0xA5. With the macro undefined: h_rvalid at T+1 with h_rdata=0x00.
- rst_n pulsed low during STROBE: cs_n and wr_n return to 1 within the same cycle; after release, busy=0 and the next request is accepted normally.
